// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard scoreboard entry layout, register-0 constant
// and stage indices of the in-flight entries tracked after ID.
package pipe_pkg;
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_ADDR_W = 5;

  localparam int ZERO_REG = 0;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  // Entry layout at the core's native widths; parameterised blocks mirror it locally.
  typedef struct packed {
    logic                   valid;
    logic [PIPE_ADDR_W-1:0] wr_addr;
    logic                   is_load;
    logic [PIPE_DATA_W-1:0] data;
    logic                   data_ok;
  } haz_entry_t;
endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID-side hazard/forwarding bus: the ID stage is the master, the hazard unit the slave.
interface pipe_hazard_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 3
);
  logic                     id_valid;
  logic [NUM_RD*ADDR_W-1:0] id_rd_addr;
  logic [NUM_RD-1:0]        id_rd_used;
  logic                     id_wr_en;
  logic [ADDR_W-1:0]        id_wr_addr;
  logic                     id_is_load;
  logic                     flush;
  logic [DATA_W-1:0]        ex_result;
  logic [DATA_W-1:0]        mem_load_data;
  logic                     stall;
  logic [NUM_RD-1:0]        fwd_hit;
  logic [NUM_RD*DATA_W-1:0] fwd_data;

  modport master (
    output id_valid, id_rd_addr, id_rd_used, id_wr_en, id_wr_addr, id_is_load,
           flush, ex_result, mem_load_data,
    input  stall, fwd_hit, fwd_data
  );

  modport slave (
    input  id_valid, id_rd_addr, id_rd_used, id_wr_en, id_wr_addr, id_is_load,
           flush, ex_result, mem_load_data,
    output stall, fwd_hit, fwd_data
  );
endinterface

// File: rtl/haz_fwd_port.sv
// Single read-port youngest-match priority mux over the in-flight entries.
// A match on a load still in EX is reported as load_use instead of a hit.
module haz_fwd_port
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3
) (
  input  logic                          used,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0]              e_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  e_addr,
  input  logic [DEPTH-1:0]              e_load,
  input  logic [DEPTH-1:0]              e_ok,
  input  logic [DEPTH-1:0][DATA_W-1:0]  e_data,
  input  logic [DATA_W-1:0]             ex_result,
  input  logic [DATA_W-1:0]             mem_load_data,
  output logic                          hit,
  output logic                          load_use,
  output logic [DATA_W-1:0]             data
);
  logic active;
  assign active = used && (addr != ADDR_W'(ZERO_REG));

  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin
    hit      = 1'b0;
    load_use = 1'b0;
    data     = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (active && e_valid[k] && (e_addr[k] == addr)) begin
        hit      = 1'b1;
        load_use = 1'b0;
        if (k == STG_EX) begin
          if (e_load[k]) begin
            hit      = 1'b0;
            load_use = 1'b1;
            data     = '0;
          end else begin
            data = ex_result;
          end
        end else if (k == STG_MEM) begin
          data = e_ok[k] ? e_data[k] : mem_load_data;
        end else begin
          data = e_data[k];
        end
      end
    end
  end
endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding unit: scoreboard of DEPTH in-flight writers, per-port forwarding,
// load-use stall and flush bubbles. HAZ_PERF_CNT_EN adds stall/flush counters.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 3,
  parameter int DEPTH  = 3
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_unit_if.slave  bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] wr_addr;
    logic              is_load;
    logic [DATA_W-1:0] data;
    logic              data_ok;
  } entry_t;

  entry_t [DEPTH-1:0]             ent;
  logic   [DEPTH-1:0]             e_valid, e_load, e_ok;
  logic   [DEPTH-1:0][ADDR_W-1:0] e_addr;
  logic   [DEPTH-1:0][DATA_W-1:0] e_data;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      e_valid[k] = ent[k].valid;
      e_addr[k]  = ent[k].wr_addr;
      e_load[k]  = ent[k].is_load;
      e_ok[k]    = ent[k].data_ok;
      e_data[k]  = ent[k].data;
    end
  end

  logic [NUM_RD-1:0]             port_hit, port_lu;
  logic [NUM_RD-1:0][DATA_W-1:0] port_data;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    haz_fwd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd (
      .used          (bus.id_rd_used[p]),
      .addr          (bus.id_rd_addr[p*ADDR_W +: ADDR_W]),
      .e_valid       (e_valid),
      .e_addr        (e_addr),
      .e_load        (e_load),
      .e_ok          (e_ok),
      .e_data        (e_data),
      .ex_result     (bus.ex_result),
      .mem_load_data (bus.mem_load_data),
      .hit           (port_hit[p]),
      .load_use      (port_lu[p]),
      .data          (port_data[p])
    );
  end

  logic stall_raw, issue, wr_track;
  assign stall_raw = bus.id_valid & ~bus.flush & (|port_lu);
  assign issue     = bus.id_valid & ~stall_raw & ~bus.flush;
  assign wr_track  = issue & bus.id_wr_en & (bus.id_wr_addr != ADDR_W'(ZERO_REG));

  assign bus.stall    = ~rst & stall_raw;
  assign bus.fwd_hit  = rst ? '0 : port_hit;
  assign bus.fwd_data = rst ? '0 : port_data;

  // The pipeline behind ID always advances; a stall or flush only injects a bubble.
  always_ff @(negedge clk) begin
    if (rst) begin
      ent <= '0;
    end else begin
      ent[STG_EX] <= '0;
      if (wr_track) begin
        ent[STG_EX].valid   <= 1'b1;
        ent[STG_EX].wr_addr <= bus.id_wr_addr;
        ent[STG_EX].is_load <= bus.id_is_load;
      end
      for (int k = 1; k < DEPTH; k++) begin
        ent[k] <= ent[k-1];
        if (k == STG_MEM) begin
          ent[k].data    <= bus.ex_result;
          ent[k].data_ok <= ~ent[k-1].is_load;
        end else if (k == STG_WB) begin
          ent[k].data    <= ent[k-1].is_load ? bus.mem_load_data : ent[k-1].data;
          ent[k].data_ok <= 1'b1;
        end
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(negedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (bus.flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif
endmodule
